soc_tcdm_rr_arbiter: RTL



---
 rtl/soc_tcdm_rr_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/soc_tcdm_rr_arbiter.sv
// rtl/soc_tcdm_rr_arbiter.sv - round-robin TCDM arbiter with in-order response ID FIFO
// Optional contention counter: define SOC_TCDM_RR_ARBITER_PERF_EN.
module soc_tcdm_rr_arbiter #(
  parameter int unsigned NR_MASTERS      = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [NR_MASTERS-1:0]                     m_req_i,
  input  logic [NR_MASTERS-1:0][ADDR_WIDTH-1:0]     m_add_i,
  input  logic [NR_MASTERS-1:0]                     m_wen_i,
  input  logic [NR_MASTERS-1:0][DATA_WIDTH-1:0]     m_wdata_i,
  input  logic [NR_MASTERS-1:0][DATA_WIDTH/8-1:0]   m_be_i,
  output logic [NR_MASTERS-1:0]                     m_gnt_o,
  output logic [NR_MASTERS-1:0]                     m_r_valid_o,
  output logic [DATA_WIDTH-1:0]                     m_r_rdata_o,
  output logic                                      m_r_opc_o,
  output logic                                      s_req_o,
  output logic [ADDR_WIDTH-1:0]                     s_add_o,
  output logic                                      s_wen_o,
  output logic [DATA_WIDTH-1:0]                     s_wdata_o,
  output logic [DATA_WIDTH/8-1:0]                   s_be_o,
  input  logic                                      s_gnt_i,
  input  logic                                      s_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                     s_r_rdata_i,
  input  logic                                      s_r_opc_i,
  output logic                                      err_o,
  output logic [31:0]                               conflict_cnt_o
);

  localparam int unsigned PTR_W   = $clog2(NR_MASTERS);
  localparam int unsigned FIFO_AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   win;
  logic               any_req;
  logic               handshake;
  logic               pop;
  logic               fifo_empty;
  logic               full_q;
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [PTR_W-1:0]   fifo_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]   head;

  function automatic logic [FIFO_AW-1:0] fifo_inc(input logic [FIFO_AW-1:0] p);
    return (int'(p) == int'(MAX_OUTSTANDING) - 1) ? '0 : p + 1'b1;
  endfunction

  // Scan from the highest offset down so the lowest offset from ptr wins last.
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    for (int i = NR_MASTERS - 1; i >= 0; i--) begin
      if (m_req_i[(int'(ptr_q) + i) % NR_MASTERS]) begin
        win     = PTR_W'((int'(ptr_q) + i) % NR_MASTERS);
        any_req = 1'b1;
      end
    end
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q) && !full_q;
  assign head       = fifo_mem[rd_ptr_q];

  // A response popping this cycle frees the slot a new grant would need.
  assign s_req_o   = rst_ni && any_req && !(full_q && !s_r_valid_i);
  assign handshake = s_req_o && s_gnt_i;
  assign pop       = rst_ni && s_r_valid_i && !fifo_empty;

  assign s_add_o   = any_req ? m_add_i[win]   : '0;
  assign s_wen_o   = any_req ? m_wen_i[win]   : 1'b0;
  assign s_wdata_o = any_req ? m_wdata_i[win] : '0;
  assign s_be_o    = any_req ? m_be_i[win]    : '0;

  assign m_r_rdata_o = s_r_rdata_i;
  assign m_r_opc_o   = s_r_opc_i;

  always_comb begin
    m_gnt_o     = '0;
    m_r_valid_o = '0;
    if (handshake) m_gnt_o[win] = 1'b1;
    if (pop)       m_r_valid_o[head] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (handshake) fifo_mem[wr_ptr_q] <= win;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      if (handshake) begin
        ptr_q    <= (int'(win) == int'(NR_MASTERS) - 1) ? '0 : win + 1'b1;
        wr_ptr_q <= fifo_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= fifo_inc(rd_ptr_q);
      if (handshake && !pop) full_q <= (fifo_inc(wr_ptr_q) == rd_ptr_q);
      else if (pop && !handshake) full_q <= 1'b0;
      if (s_r_valid_i && fifo_empty) err_o <= 1'b1;
    end
  end

`ifdef SOC_TCDM_RR_ARBITER_PERF_EN
  logic [31:0] conflict_cnt_q;
  logic        multi_req;

  // x & (x-1) clears the lowest set bit; anything left means two or more requesters.
  assign multi_req = |(m_req_i & (m_req_i - 1'b1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      conflict_cnt_q <= '0;
    end else if (multi_req && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
      conflict_cnt_q <= conflict_cnt_q + 32'd1;
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;
`else
  assign conflict_cnt_o = '0;
`endif

endmodule
